// File: rtl/pipe_stage_reg.sv
// Purpose: handshaked pipeline register carrying PC/instr/payload/hazard metadata between core stages.
// Latency: one cycle from in_fire to the entry on out_*.
// Backpressure: holds while out_ready=0; the optional skid entry lets in_ready be a registered signal.
//
// Ports:
//   clk, reset (async, active-low), flush (sync kill of all held entries)
//   in_valid/in_ready + in_pc, in_instr, in_data, in_op, in_grf_write, in_grf_a3, in_tnew
//   out_valid/out_ready + out_pc, out_instr, out_data, out_op, out_grf_write, out_grf_a3, out_tnew
// Build option: define PIPE_STAGE_REG_SKID_EN to add a second (skid) entry behind the output register.
module pipe_stage_reg #(
  parameter int DATA_W = 96,
  parameter int A3_W   = 5,
  parameter int TNEW_W = 4,
  parameter int OP_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OP_W-1:0]   in_op,
  input  logic              in_grf_write,
  input  logic [A3_W-1:0]   in_grf_a3,
  input  logic [TNEW_W-1:0] in_tnew,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr,
  output logic [DATA_W-1:0] out_data,
  output logic [OP_W-1:0]   out_op,
  output logic              out_grf_write,
  output logic [A3_W-1:0]   out_grf_a3,
  output logic [TNEW_W-1:0] out_tnew
);

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       instr;
    logic [DATA_W-1:0] data;
    logic [OP_W-1:0]   op;
    logic              grf_write;
    logic [A3_W-1:0]   a3;
    logic [TNEW_W-1:0] tnew;
  } entry_t;

  entry_t in_ent;
  entry_t m_q;
  logic   m_vld;
  logic   in_fire;
  logic   out_fire;

  // Tnew counts down by one stage on capture, saturating at zero.
  always_comb begin
    in_ent           = '0;
    in_ent.pc        = in_pc;
    in_ent.instr     = in_instr;
    in_ent.data      = in_data;
    in_ent.op        = in_op;
    in_ent.grf_write = in_grf_write;
    in_ent.a3        = in_grf_a3;
    in_ent.tnew      = (in_tnew == '0) ? '0 : in_tnew - TNEW_W'(1);
  end

  assign in_fire  = in_valid & in_ready & ~flush;
  assign out_fire = m_vld & out_ready;

`ifdef PIPE_STAGE_REG_SKID_EN
  entry_t s_q;
  logic   s_vld;

  // Ready depends only on skid occupancy, so it is a flop output.
  assign in_ready = ~s_vld;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q   <= '0;
      m_vld <= 1'b0;
      s_q   <= '0;
      s_vld <= 1'b0;
    end else if (flush) begin
      m_q   <= '0;
      m_vld <= 1'b0;
      s_q   <= '0;
      s_vld <= 1'b0;
    end else if (out_fire || !m_vld) begin
      // M is free this edge: the older skid entry goes first to keep FIFO order.
      // S is only ever occupied while M is valid, so an empty M implies empty S.
      if (s_vld) begin
        m_q   <= s_q;
        m_vld <= 1'b1;
        s_q   <= '0;
        s_vld <= 1'b0;
      end else if (in_fire) begin
        m_q   <= in_ent;
        m_vld <= 1'b1;
      end else begin
        m_q   <= '0;
        m_vld <= 1'b0;
      end
    end else if (in_fire) begin
      // M stalled with a valid entry: park the incoming entry in S.
      s_q   <= in_ent;
      s_vld <= 1'b1;
    end
  end
`else
  assign in_ready = ~m_vld | out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q   <= '0;
      m_vld <= 1'b0;
    end else if (flush) begin
      m_q   <= '0;
      m_vld <= 1'b0;
    end else if (in_fire) begin
      m_q   <= in_ent;
      m_vld <= 1'b1;
    end else if (out_fire) begin
      m_q   <= '0;
      m_vld <= 1'b0;
    end
  end
`endif

  assign out_valid     = m_vld;
  assign out_pc        = m_q.pc;
  assign out_instr     = m_q.instr;
  assign out_data      = m_q.data;
  assign out_op        = m_q.op;
  assign out_grf_write = m_q.grf_write;
  assign out_grf_a3    = m_q.a3;
  assign out_tnew      = m_q.tnew;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Purpose: directed self-checking bench for pipe_stage_reg (single-register or skid build).
// Latency: stimulus applied 1 time unit after each rising edge, outputs sampled at the same point.
// Backpressure: out_ready driven directly by the stimulus sequence.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_REG_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic [95:0] in_data;
  logic [7:0]  in_op;
  logic        in_grf_write;
  logic [4:0]  in_grf_a3;
  logic [3:0]  in_tnew;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [95:0] out_data;
  logic [7:0]  out_op;
  logic        out_grf_write;
  logic [4:0]  out_grf_a3;
  logic [3:0]  out_tnew;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_pc         (in_pc),
    .in_instr      (in_instr),
    .in_data       (in_data),
    .in_op         (in_op),
    .in_grf_write  (in_grf_write),
    .in_grf_a3     (in_grf_a3),
    .in_tnew       (in_tnew),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .out_data      (out_data),
    .out_op        (out_op),
    .out_grf_write (out_grf_write),
    .out_grf_a3    (out_grf_a3),
    .out_tnew      (out_tnew)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] tin [3];
  logic [3:0] texp[3];

  initial begin
    tin[0] = 4'd0;  texp[0] = 4'd0;
    tin[1] = 4'd1;  texp[1] = 4'd0;
    tin[2] = 4'd15; texp[2] = 4'd14;

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0; in_data = '0; in_op = '0;
    in_grf_write = 1'b0; in_grf_a3 = '0; in_tnew = '0;

    // Reset state, before and across a clock edge.
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_pc", out_pc, 0);
    step();
    chk("rst_hold_valid", out_valid, 0);
    reset = 1'b1;

    // Pass-through.
    out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'h3000; in_instr = 32'h0000_1234;
    in_data = 96'hABC_0000_0000_0000_0DEF; in_op = 8'h5A;
    in_grf_write = 1'b1; in_grf_a3 = 5'd5; in_tnew = 4'd2;
    step();
    chk("pt_valid", out_valid, 1);
    chk("pt_pc", out_pc, 32'h3000);
    chk("pt_a3", out_grf_a3, 5);
    chk("pt_tnew", out_tnew, 1);
    chk("pt_gw", out_grf_write, 1);
    chk("pt_instr", out_instr, 32'h0000_1234);
    chk("pt_data", out_data, 96'hABC_0000_0000_0000_0DEF);
    chk("pt_op", out_op, 8'h5A);

    // Tnew saturation.
    for (int i = 0; i < 3; i++) begin
      in_tnew = tin[i];
      step();
      chk("tnew_sat", out_tnew, texp[i]);
    end
    in_valid = 1'b0;
    step();
    chk("drain_valid", out_valid, 0);
    chk("drain_gw", out_grf_write, 0);
    chk("drain_pc", out_pc, 0);

    // Stall hold.
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h3004; in_tnew = 4'd3;
    step();
    chk("stall_pc0", out_pc, 32'h3004);
    chk("stall_tnew0", out_tnew, 2);
    in_pc = 32'h3008;
    chk("stall_in_ready", in_ready, SKID);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", out_valid, 1);
      chk("stall_pc", out_pc, 32'h3004);
      chk("stall_tnew", out_tnew, 2);
      chk("stall_rdy", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("release_pc", out_pc, 32'h3004);
    step();
    in_valid = 1'b0;
    chk("release_next_valid", out_valid, 1);
    chk("release_next_pc", out_pc, 32'h3008);
    chk("release_next_tnew", out_tnew, 2);
    step();
    chk("release_empty", out_valid, 0);

    // Flush with a held entry and a simultaneous incoming entry.
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h3010; in_tnew = 4'd1;
    step();
    chk("pre_flush_pc", out_pc, 32'h3010);
    in_pc = 32'h300c; flush = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, SKID);
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush_valid", out_valid, 0);
    chk("flush_gw", out_grf_write, 0);
    chk("flush_a3", out_grf_a3, 0);
    chk("flush_pc", out_pc, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("post_flush_valid", out_valid, 0);
      chk("post_flush_pc", out_pc, 0);
    end

    // Asynchronous reset mid-stall.
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h3014; in_tnew = 4'd2;
    step();
    in_pc = 32'h3018;
    step();
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_pc", out_pc, 0);
    chk("arst_a3", out_grf_a3, 0);
    chk("arst_gw", out_grf_write, 0);
    chk("arst_tnew", out_tnew, 0);
    chk("arst_in_ready", in_ready, 1);
    step();
    reset = 1'b1; out_ready = 1'b1;
    chk("arst_rel_ready", in_ready, 1);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("arst_no_stale", out_valid, 0);
    end

    // Back-to-back streaming.
    in_valid = 1'b1; in_tnew = 4'd3;
    for (int k = 0; k < 8; k++) begin
      in_pc   = 32'h3000 + 32'(4 * k);
      in_data = 96'(k) + 96'h100;
      chk("stream_in_ready", in_ready, 1);
      step();
      chk("stream_valid", out_valid, 1);
      chk("stream_pc", out_pc, 32'h3000 + 32'(4 * k));
      chk("stream_data", out_data, 96'(k) + 96'h100);
    end
    in_valid = 1'b0;
    step();
    chk("stream_end", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, handshaked successor to the fixed E/M-style pipeline register.
- Carries PC, instruction, a bundled payload and hazard metadata (GRF write enable, A3, Tnew) between any two stages of the 5-stage core.
- Replaces the global stage-enable with a valid/ready handshake, a synchronous flush, and an optional 2-entry skid buffer so upstream ready can be registered.

Parameters:
- DATA_W, 96, width of bundled payload (e.g. RD2/ALUout/MDUout or other stage data).
- A3_W, 5, GRF destination address width.
- TNEW_W, 4, width of the Tnew field.
- OP_W, 8, width of bundled control opcode field (DMop/BEop/DatatoReg packed).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  block accepts entry this cycle
- in_pc  in  32  entry PC
- in_instr  in  32  entry instruction
- in_data  in  DATA_W  payload
- in_op  in  OP_W  control opcode bundle
- in_grf_write  in  1  entry writes GRF
- in_grf_a3  in  A3_W  GRF destination
- in_tnew  in  TNEW_W  Tnew in upstream stage
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts
- out_pc / out_instr / out_data / out_op  out  32/32/DATA_W/OP_W  held entry fields
- out_grf_write  out  1  held entry writes GRF (0 for bubbles)
- out_grf_a3  out  A3_W  held destination (0 for bubbles)
- out_tnew  out  TNEW_W  Tnew in this stage

Behaviour:
- Fire terms: in_fire = in_valid & in_ready & ~flush; out_fire = out_valid & out_ready.
- Reset (reset=0, async): all out_* = 0, out_valid = 0, any skid entry invalid, in_ready = 1. Effect is immediate, with no clock edge required.
- Tnew on capture: stored = (in_tnew == 0) ? 0 : in_tnew - 1 (saturating). An entry held across stalls keeps its Tnew; no further decrement.
- Bubble: valid = 0, grf_write = 0, a3 = 0, tnew = 0, pc = 0, instr = 0. Data and op are don't-care but must not cause a GRF write.
- Single-register mode (macro off):
  - in_ready = ~out_valid | out_ready, combinational.
  - Edge with in_fire: output register loads the entry, out_valid = 1.
  - Edge with out_fire and no in_fire: output register becomes a bubble.
  - Neither: hold all fields.
  - Latency: in_fire at edge N gives the entry on outputs after edge N.
- Flush: takes priority over every other event. At the edge, all entries become bubbles, out_valid = 0, and the simultaneous in_valid is dropped. in_ready is unaffected by flush.
- Simultaneous in_fire and out_fire with one entry held: outgoing entry leaves, incoming entry loads; no bubble cycle.
- out_valid is never deasserted without out_fire, flush or reset.
- Entry ordering strictly FIFO; no entry duplicated or lost except by flush.

Optional Feature:
Macro PIPE_STAGE_REG_SKID_EN.
- Defined: adds skid register S behind output register M.
  - in_ready = ~S_valid, a registered signal.
  - in_fire while M holds a valid entry and ~out_ready: entry goes to S.
  - out_fire: M loads S if S_valid (S becomes bubble), else the in_fire entry, else becomes a bubble.
  - At most 2 entries held. Full when S_valid; in_ready falls 1 cycle after filling.
  - S entries carry already-decremented Tnew unchanged into M.
  - Flush and reset clear both M and S.
- Undefined: single-register behaviour above; no S storage synthesised.

Test Plan:
- Reset then pass-through: release reset, out_ready=1, in_valid=1 with pc=0x3000, a3=5, grf_write=1, tnew=2 -> next cycle out_valid=1, out_pc=0x3000, out_grf_a3=5, out_tnew=1.
- Tnew saturation: in_tnew=0 -> out_tnew=0; in_tnew=1 -> 0; in_tnew=15 -> 14.
- Stall hold: out_ready=0 for 3 cycles with entry pc=0x3004, tnew=3 -> outputs constant with out_tnew=2. Non-skid: in_ready=0. Skid: one extra entry pc=0x3008 accepted, then in_ready=0 next cycle. On out_ready=1, pc 0x3004 then 0x3008 appear on consecutive cycles.
- Flush with in_valid=1 (pc=0x300c) and one held entry -> after edge out_valid=0, out_grf_write=0, out_grf_a3=0, out_pc=0. pc 0x300c never appears.
- Async reset mid-stall: assert reset between edges with two held entries -> out_valid=0 and all outputs 0 immediately. After release, in_ready=1 and no stale entry emerges.
- Back-to-back streaming: 8 entries pc=0x3000+4k, in_valid=1, out_ready=1 -> outputs in order, one per cycle, no bubbles, in_ready constantly 1.
